// File: rtl/car_pkg.sv
// Shared encodings for the car controller: FSM states, driving-mode codes and
// odometer limits.
package car_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_IDLE   = 2'b01,
    ST_MOVING = 2'b10,
    ST_FULL   = 2'b11
  } state_t;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SEMI   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;

  localparam logic [3:0] MANUAL_MOVING = 4'b0100;

  localparam int unsigned MAX_MILEAGE = 99_999_999;

endpackage

// File: rtl/tick_prescaler.sv
// Enable generator: counts while en is high, clears when en drops, and raises
// tick_en (registered) for the cycle in which the count sits at PERIOD-1.
module tick_prescaler #(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_en
);

  localparam int unsigned W = $clog2(PERIOD);
  localparam logic [W-1:0] TERM     = W'(PERIOD - 1);
  localparam logic [W-1:0] PRE_TERM = W'(PERIOD - 2);

  logic [W-1:0] cnt;

  // tick_en is registered one count early so it lines up with cnt == TERM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      tick_en <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      tick_en <= 1'b0;
    end else begin
      tick_en <= (cnt == PRE_TERM);
      cnt     <= (cnt == TERM) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/mileage_scheduler.sv
// Odometer owner: picks the active movement requester by driving mode, paces
// increments from a prescaler enable, and handles power-off, clear and saturation.
module mileage_scheduler #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 2,
  parameter int unsigned MAX_MILEAGE = car_pkg::MAX_MILEAGE,
  parameter int unsigned REC_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_now,
  input  logic [1:0]       mode,
  input  logic [3:0]       manual_state,
  input  logic             semi_move,
  input  logic             auto_move,
  input  logic             clear_req,
  output logic [REC_W-1:0] record,
  output logic             moving,
  output logic             tick,
  output logic             full
);

  import car_pkg::*;

  localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(MAX_MILEAGE);

  state_t           state_q, state_d;
  logic [REC_W-1:0] record_d;
  logic             tick_d;
  logic             move_sel_c;
  logic             pre_en_c;
  logic             tick_en;

  always_comb begin
    move_sel_c = 1'b0;
    case (mode)
      MODE_MANUAL: move_sel_c = (manual_state == MANUAL_MOVING);
      MODE_SEMI:   move_sel_c = semi_move;
      MODE_AUTO:   move_sel_c = auto_move;
      default:     move_sel_c = 1'b0;
    endcase
  end

  // Prescaler runs only on cycles where MOVING would not be left
  assign pre_en_c = (state_q == ST_MOVING) && power_now && !clear_req && move_sel_c;

  tick_prescaler #(.PERIOD(PERIOD)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (pre_en_c),
    .tick_en (tick_en)
  );

  always_comb begin
    state_d  = state_q;
    record_d = record;
    tick_d   = 1'b0;
    if (!power_now) begin
      state_d  = ST_OFF;
      record_d = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          if (clear_req)                state_d = ST_IDLE;
          else if (move_sel_c && !full) state_d = ST_MOVING;
          if (clear_req) record_d = '0;
        end
        ST_MOVING: begin
          if (clear_req) begin
            record_d = '0;
            state_d  = ST_IDLE;
          end else if (!move_sel_c) begin
            state_d = ST_IDLE;
          end else if (tick_en && record < REC_MAX) begin
            record_d = record + REC_W'(1);
            tick_d   = 1'b1;
            if (record + REC_W'(1) == REC_MAX) state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (clear_req) begin
            record_d = '0;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      record  <= '0;
      tick    <= 1'b0;
      full    <= 1'b0;
      moving  <= 1'b0;
    end else begin
      state_q <= state_d;
      record  <= record_d;
      tick    <= tick_d;
      full    <= (record_d == REC_MAX);
      moving  <= (state_d == ST_MOVING);
    end
  end

endmodule

// File: tb/tb_mileage_scheduler.sv
// Scoreboard bench for mileage_scheduler with a 4-cycle tick period and a
// saturation value of 5.
module tb_mileage_scheduler;

  localparam int unsigned CLK_HZ  = 8;
  localparam int unsigned TICK_HZ = 2;
  localparam int unsigned MAXM    = 5;
  localparam int unsigned REC_W   = 27;
  localparam int PERIOD = CLK_HZ / TICK_HZ;

  localparam int M_OFF = 0, M_IDLE = 1, M_MOV = 2, M_FULL = 3;

  typedef struct {
    int rec;
    int mov;
    int tck;
    int ful;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             power_now;
  logic [1:0]       mode;
  logic [3:0]       manual_state;
  logic             semi_move;
  logic             auto_move;
  logic             clear_req;
  logic [REC_W-1:0] record;
  logic             moving;
  logic             tick;
  logic             full;

  int total = 0;
  int bad   = 0;

  int m_state, m_rec, m_pc;
  exp_t sb[$];

  always #5 clk = ~clk;

  mileage_scheduler #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MILEAGE(MAXM), .REC_W(REC_W)
  ) dut (
    .clk(clk), .rst(rst), .power_now(power_now), .mode(mode),
    .manual_state(manual_state), .semi_move(semi_move), .auto_move(auto_move),
    .clear_req(clear_req), .record(record), .moving(moving), .tick(tick),
    .full(full)
  );

  task automatic check(input string tag, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_OFF;
    m_rec   = 0;
    m_pc    = 0;
  endtask

  // Drive one cycle of inputs, predict the outputs, compare after the edge.
  task automatic step(input bit pw, input bit [1:0] md, input bit [3:0] ms,
                      input bit sm, input bit am, input bit clr);
    bit   sel;
    int   tk;
    exp_t e;
    power_now = pw; mode = md; manual_state = ms;
    semi_move = sm; auto_move = am; clear_req = clr;
    sel = (md == 2'b00) ? (ms == 4'b0100) : (md == 2'b01) ? sm : (md == 2'b10) ? am : 1'b0;
    tk = 0;
    if (!pw) begin
      m_state = M_OFF; m_rec = 0; m_pc = 0;
    end else if (m_state == M_OFF) begin
      m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (clr) m_rec = 0;
      else if (sel && m_rec != MAXM) begin m_state = M_MOV; m_pc = 0; end
    end else if (m_state == M_MOV) begin
      if (clr)       begin m_rec = 0; m_state = M_IDLE; m_pc = 0; end
      else if (!sel) begin m_state = M_IDLE; m_pc = 0; end
      else begin
        m_pc++;
        if (m_pc == PERIOD) begin
          m_pc = 0; m_rec++; tk = 1;
          if (m_rec == MAXM) m_state = M_FULL;
        end
      end
    end else begin
      if (clr) begin m_rec = 0; m_state = M_IDLE; end
    end
    e.rec = m_rec; e.mov = (m_state == M_MOV); e.tck = tk; e.ful = (m_rec == MAXM);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("record", int'(record), e.rec);
    check("moving", int'(moving), e.mov);
    check("tick",   int'(tick),   e.tck);
    check("full",   int'(full),   e.ful);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_record"}, int'(record), 0);
    check({tag, "_moving"}, int'(moving), 0);
    check({tag, "_tick"},   int'(tick),   0);
    check({tag, "_full"},   int'(full),   0);
  endtask

  task automatic man(input int n);
    for (int i = 0; i < n; i++) step(1, 2'b00, 4'b0100, 0, 0, 0);
  endtask

  initial begin
    bit pw, sm, am, clr;
    bit [1:0] md;
    bit [3:0] ms;

    // reset with random inputs
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      power_now = 1'($urandom); mode = 2'($urandom); manual_state = 4'($urandom);
      semi_move = 1'($urandom); auto_move = 1'($urandom); clear_req = 1'($urandom);
      @(posedge clk); #1;
      check_zero("reset");
    end
    power_now = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 2'b00, 4'b0100, 1, 1, 0);
    check_zero("unpowered");

    // manual move: 3 ticks in 12 cycles of MOVING
    step(1, 2'b00, 4'b0100, 0, 0, 0);
    step(1, 2'b00, 4'b0100, 0, 0, 0);
    man(12);
    check("manual_rec3", int'(record), 3);
    step(1, 2'b00, 4'b0100, 0, 0, 1);
    check("manual_clear", int'(record), 0);
    step(1, 2'b00, 4'b0100, 0, 0, 0);
    man(5);
    step(1, 2'b00, 4'b0010, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2'b00, 4'b0010, 0, 0, 0);
    check("manual_stop_rec1", int'(record), 1);
    check("manual_stop_idle", int'(moving), 0);

    // mode arbitration
    step(1, 2'b01, 4'b0000, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 2'b01, 4'b0100, 0, 1, 0);
    check("semi_ignores_auto", int'(record), 0);
    for (int i = 0; i < 9; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    check("auto_rec2", int'(record), 2);

    // saturation
    for (int i = 0; i < 40; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    check("sat_rec", int'(record), int'(MAXM));
    check("sat_full", int'(full), 1);
    step(1, 2'b10, 4'b0000, 0, 1, 1);
    check("sat_clear_full", int'(full), 0);

    // power-off mid-move with record=3, prescaler=2
    step(1, 2'b10, 4'b0000, 0, 0, 0);
    step(1, 2'b10, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 14; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    check("pre_off_rec3", int'(record), 3);
    step(0, 2'b10, 4'b0000, 0, 1, 0);
    check("poweroff_rec0", int'(record), 0);
    step(1, 2'b10, 4'b0000, 0, 1, 0);
    step(1, 2'b10, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    check("repower_no_early_tick", int'(record), 0);
    step(1, 2'b10, 4'b0000, 0, 1, 0);
    check("repower_first_tick", int'(record), 1);

    // clear on a terminal-count cycle
    for (int i = 0; i < 3; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    step(1, 2'b10, 4'b0000, 0, 1, 1);
    check("tc_clear_tick", int'(tick), 0);
    check("tc_clear_rec", int'(record), 0);

    // power-off beats clear
    for (int i = 0; i < 6; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    step(0, 2'b10, 4'b0000, 0, 1, 1);
    check_zero("off_and_clear");

    // async reset in the middle of a cycle
    for (int i = 0; i < 8; i++) step(1, 2'b10, 4'b0000, 0, 1, 0);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    power_now = 1'b0;
    rst = 1'b1;
    model_reset();

    // random segment with held input patterns
    pw = 1; md = 2'b10; ms = 4'b0100; sm = 1; am = 1; clr = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        pw = ($urandom_range(0, 15) != 0);
        md = 2'($urandom);
        ms = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'($urandom);
        sm = ($urandom_range(0, 3) != 0);
        am = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 29) == 0);
      step(pw, md, ms, sm, am, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
